// File: rtl/ff_autoplay_pkg.sv
// Shared types and helpers for the foodfight auto-play sequencer.
// MANUAL reuses the DONE encoding; the sequencer keeps a separate flag to tell them apart.
package ff_autoplay_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StBoot  = 3'd1,
        StCoin  = 3'd2,
        StGap1  = 3'd3,
        StStart = 3'd4,
        StGap2  = 3'd5,
        StPlay  = 3'd6,
        StDone  = 3'd7
    } state_e;

    function automatic int unsigned ms_width(input int unsigned max_ms);
        return $clog2(max_ms + 1);
    endfunction

endpackage

// File: rtl/ff_ms_tick.sv
// Free-running millisecond strobe: one-cycle ms_tick every CLK_HZ/1000 clocks.
module ff_ms_tick #(
    parameter int unsigned CLK_HZ = 12000000
) (
    input  logic clk12m,
    input  logic reset,
    output logic ms_tick
);

    localparam int unsigned Div  = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] Last = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == Last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk12m) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ms_tick = (cnt_q == Last);

endmodule

// File: rtl/ff_autoplay_seq.sv
// Auto-play sequencer: boots, inserts a coin, starts 1P and throws until PLAY_MS expires.
// Define FF_AUTOPLAY_LOOP_EN to return to BOOT after PLAY for an endless attract demo.
module ff_autoplay_seq
    import ff_autoplay_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 12000000,
    parameter int unsigned BOOT_MS  = 3000,
    parameter int unsigned PULSE_MS = 100,
    parameter int unsigned GAP_MS   = 1000,
    parameter int unsigned THROW_MS = 500,
    parameter int unsigned PLAY_MS  = 60000
) (
    input  logic       clk12m,
    input  logic       reset,
    input  logic       enable,
    input  logic       manual_act,
    output logic       auto_coin_n,
    output logic       auto_start_n,
    output logic       auto_throw_n,
    output logic       busy,
    output logic [2:0] state_o
);

    localparam int unsigned Max01 = (BOOT_MS > PULSE_MS) ? BOOT_MS : PULSE_MS;
    localparam int unsigned Max23 = (GAP_MS > THROW_MS) ? GAP_MS : THROW_MS;
    localparam int unsigned Max03 = (Max01 > Max23) ? Max01 : Max23;
    localparam int unsigned MaxMs = (Max03 > PLAY_MS) ? Max03 : PLAY_MS;
    localparam int unsigned MsW   = ms_width(MaxMs);
    localparam int unsigned ThrW  = ms_width(THROW_MS);

`ifdef FF_AUTOPLAY_LOOP_EN
    localparam state_e PlayExit = StBoot;
`else
    localparam state_e PlayExit = StDone;
`endif

    if (!(PULSE_MS < THROW_MS && PULSE_MS < GAP_MS)) begin : g_bad_cfg
        $error("ff_autoplay_seq: PULSE_MS must be below both THROW_MS and GAP_MS");
    end

    logic ms_tick;

    ff_ms_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_ms_tick (
        .clk12m (clk12m),
        .reset  (reset),
        .ms_tick(ms_tick)
    );

    state_e          state_q, state_d;
    logic            manual_q, manual_d;
    logic [MsW-1:0]  ms_q, ms_d;
    logic [ThrW-1:0] thr_q, thr_d;
    logic            coin_n_q, coin_n_d;
    logic            start_n_q, start_n_d;
    logic            throw_n_q, throw_n_d;
    logic            busy_q, busy_d;

    // Operator activity outranks enable, which outranks every timer expiry.
    always_comb begin
        state_d  = state_q;
        manual_d = manual_q;
        if (state_q != StDone) begin
            if (manual_act) begin
                state_d  = StDone;
                manual_d = 1'b1;
            end else if (!enable) begin
                state_d = StIdle;
            end else begin
                case (state_q)
                    StIdle:  state_d = StBoot;
                    StBoot:  if (ms_q == MsW'(BOOT_MS))  state_d = StCoin;
                    StCoin:  if (ms_q == MsW'(PULSE_MS)) state_d = StGap1;
                    StGap1:  if (ms_q == MsW'(GAP_MS))   state_d = StStart;
                    StStart: if (ms_q == MsW'(PULSE_MS)) state_d = StGap2;
                    StGap2:  if (ms_q == MsW'(GAP_MS))   state_d = StPlay;
                    StPlay:  if (ms_q == MsW'(PLAY_MS))  state_d = PlayExit;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        ms_d  = ms_q;
        thr_d = thr_q;
        if (state_d != state_q) begin
            ms_d  = '0;
            thr_d = '0;
        end else if (ms_tick) begin
            if (ms_q != MsW'(MaxMs)) begin
                ms_d = ms_q + MsW'(1);
            end
            thr_d = (thr_q == ThrW'(THROW_MS - 1)) ? '0 : thr_q + ThrW'(1);
        end
    end

    // Outputs follow the registered state, so they lag a state change by one cycle.
    always_comb begin
        coin_n_d  = (state_q != StCoin);
        start_n_d = (state_q != StStart);
        throw_n_d = !((state_q == StPlay) && (thr_q < ThrW'(PULSE_MS))
                      && (ms_q < MsW'(PLAY_MS)));
        busy_d    = (state_q != StIdle) && (state_q != StDone);
    end

    always_ff @(posedge clk12m) begin
        if (reset) begin
            state_q   <= StIdle;
            manual_q  <= 1'b0;
            ms_q      <= '0;
            thr_q     <= '0;
            coin_n_q  <= 1'b1;
            start_n_q <= 1'b1;
            throw_n_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            manual_q  <= manual_d;
            ms_q      <= ms_d;
            thr_q     <= thr_d;
            coin_n_q  <= coin_n_d;
            start_n_q <= start_n_d;
            throw_n_q <= throw_n_d;
            busy_q    <= busy_d;
        end
    end

    assign auto_coin_n  = coin_n_q;
    assign auto_start_n = start_n_q;
    assign auto_throw_n = throw_n_q;
    assign busy         = busy_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_ff_autoplay_seq.sv
// Randomized bench for ff_autoplay_seq against a table-driven millisecond-level model.
module tb_ff_autoplay_seq;

    localparam int Div     = 4;
    localparam int BootMs  = 5;
    localparam int PulseMs = 2;
    localparam int GapMs   = 3;
    localparam int ThrowMs = 4;
    localparam int PlayMs  = 12;
    localparam int MaxMs   = 12;

    localparam int PIdle = 0, PBoot = 1, PCoin = 2, PGap1 = 3, PStart = 4, PGap2 = 5;
    localparam int PPlay = 6, PDone = 7, PManual = 8;

`ifdef FF_AUTOPLAY_LOOP_EN
    localparam int PlayExit = PBoot;
`else
    localparam int PlayExit = PDone;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, manual_act;
    logic       auto_coin_n, auto_start_n, auto_throw_n, busy;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    ff_autoplay_seq #(
        .CLK_HZ  (4000),
        .BOOT_MS (BootMs),
        .PULSE_MS(PulseMs),
        .GAP_MS  (GapMs),
        .THROW_MS(ThrowMs),
        .PLAY_MS (PlayMs)
    ) dut (
        .clk12m      (clk),
        .reset       (reset),
        .enable      (enable),
        .manual_act  (manual_act),
        .auto_coin_n (auto_coin_n),
        .auto_start_n(auto_start_n),
        .auto_throw_n(auto_throw_n),
        .busy        (busy),
        .state_o     (state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Model: phase in a fixed sequence, ms elapsed in it, and the global clock phase.
    int   dur [7] = '{0, BootMs, PulseMs, GapMs, PulseMs, GapMs, PlayMs};
    int   m_phase, m_ms, m_presc;
    logic m_coin, m_start, m_throw, m_busy;

    task automatic model_edge(input logic rst, input logic en, input logic man);
        int nxt;
        bit tick;
        if (rst) begin
            m_phase = PIdle;
            m_ms    = 0;
            m_presc = 0;
            m_coin  = 1'b1;
            m_start = 1'b1;
            m_throw = 1'b1;
            m_busy  = 1'b0;
            return;
        end
        tick    = (m_presc == Div - 1);
        m_coin  = (m_phase != PCoin);
        m_start = (m_phase != PStart);
        m_throw = !(m_phase == PPlay && (m_ms % ThrowMs) < PulseMs && m_ms < PlayMs);
        m_busy  = (m_phase >= PBoot && m_phase <= PPlay);
        nxt = m_phase;
        if (m_phase >= PDone) nxt = m_phase;
        else if (man) nxt = PManual;
        else if (!en) nxt = PIdle;
        else if (m_phase == PIdle) nxt = PBoot;
        else if (m_ms == dur[m_phase]) nxt = (m_phase == PPlay) ? PlayExit : m_phase + 1;
        if (nxt != m_phase) m_ms = 0;
        else if (tick && m_ms < MaxMs) m_ms++;
        m_phase = nxt;
        m_presc = (m_presc + 1) % Div;
    endtask

    task automatic step(input logic rst, input logic en, input logic man);
        int lows;
        reset      = rst;
        enable     = en;
        manual_act = man;
        @(posedge clk);
        model_edge(rst, en, man);
        @(negedge clk);
        check_eq("coin_n", auto_coin_n, m_coin);
        check_eq("start_n", auto_start_n, m_start);
        check_eq("throw_n", auto_throw_n, m_throw);
        check_eq("busy", busy, m_busy);
        check_eq("state", state_o, (m_phase == PManual) ? 7 : m_phase);
        lows = 0;
        if (!auto_coin_n) lows++;
        if (!auto_start_n) lows++;
        if (!auto_throw_n) lows++;
        check_eq("one_low", lows <= 1, 1);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        manual_act = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int ep = 0; ep < 60; ep++) begin
            int mode, len, delay;
            logic rst, en, man;
            mode  = ep % 3;
            len   = $urandom_range(140, 300);
            delay = $urandom_range(0, 10);
            step(1'b1, 1'b1, 1'b0);
            for (int c = 0; c < len; c++) begin
                rst = (mode != 0) && ($urandom_range(0, 599) == 0);
                man = (mode == 1) && ($urandom_range(0, 299) == 0);
                en  = (c >= delay);
                if (mode == 2 && $urandom_range(0, 79) == 0) en = 1'b0;
                step(rst, en, man);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
